// File: rtl/accum_bank_if.sv
// accum_bank_if: control, sample stream, status and snapshot readout bundle for accum_bank (ovf only with ACCUM_SAT_EN)
interface accum_bank_if #(
    parameter int DATA_W   = 12,
    parameter int POINTS   = 10,
    parameter int MEASURES = 100000,
    parameter int SUM_W    = 29
);
    localparam int PT_W   = $clog2(POINTS);
    localparam int MEAS_W = $clog2(MEASURES);

    logic              i_start;
    logic              i_abort;
    logic              i_cont;
    logic              i_sof;
    logic              i_s_valid;
    logic [DATA_W-1:0] i_s_data;
    logic [PT_W-1:0]   i_rd_addr;
    logic [SUM_W-1:0]  o_rd_data;
    logic              o_busy;
    logic              o_done;
    logic [MEAS_W-1:0] o_frame_cnt;
    logic              o_short_frame;
    logic              o_long_frame;
`ifdef ACCUM_SAT_EN
    logic              o_ovf;
`endif

    modport master (
        output i_start, i_abort, i_cont, i_sof, i_s_valid, i_s_data, i_rd_addr,
        input  o_rd_data, o_busy, o_done, o_frame_cnt, o_short_frame, o_long_frame
`ifdef ACCUM_SAT_EN
        , input o_ovf
`endif
    );

    modport slave (
        input  i_start, i_abort, i_cont, i_sof, i_s_valid, i_s_data, i_rd_addr,
        output o_rd_data, o_busy, o_done, o_frame_cnt, o_short_frame, o_long_frame
`ifdef ACCUM_SAT_EN
        , output o_ovf
`endif
    );
endinterface

// File: rtl/accum_bank.sv
// accum_bank: point-wise frame accumulator with start/abort FSM and double-buffered addressed snapshot; ACCUM_SAT_EN selects saturating adds plus ovf flag
module accum_bank #(
    parameter int DATA_W   = 12,
    parameter int POINTS   = 10,
    parameter int MEASURES = 100000,
    parameter int SUM_W    = 29
) (
    input logic         clk,
    input logic         rst_n,
    accum_bank_if.slave bus
);
    localparam int PT_W   = $clog2(POINTS);
    localparam int MEAS_W = $clog2(MEASURES);
    // point counter one bit wider so that the value POINTS means "frame complete, waiting for sof"
    localparam int CNT_W  = PT_W + 1;
    localparam logic [CNT_W-1:0]  PT_FULL  = CNT_W'(POINTS);
    localparam logic [CNT_W-1:0]  PT_LAST  = CNT_W'(POINTS - 1);
    localparam logic [MEAS_W-1:0] CNT_LAST = MEAS_W'(MEASURES - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT_SOF, S_ACCUM, S_DUMP} state_t;

    state_t            r_state, w_state_nxt;
    logic [SUM_W-1:0]  r_acc     [POINTS];
    logic [SUM_W-1:0]  r_snap    [POINTS];
    logic [SUM_W-1:0]  w_base    [POINTS];
    logic [SUM_W-1:0]  w_acc_nxt [POINTS];
    logic [SUM_W-1:0]  w_sel, w_sum, w_rd, r_rd;
    logic [CNT_W-1:0]  r_pt, w_bpt, w_idx, w_pt_nxt;
    logic [MEAS_W-1:0] r_cnt, w_bcnt, w_cnt_nxt;
    logic [DATA_W-1:0] r_carry_d;
    logic              r_cont, r_short, r_long, r_carry_v;
    logic              w_abort, w_start, w_dump, w_run, w_clr, w_v, w_mid;
    logic              w_short, w_wr, w_long, w_cmp, w_fin_s, w_fin_c, w_fin, w_wr_acc;
`ifdef ACCUM_SAT_EN
    logic [SUM_W:0]    w_sum_x;
    logic              w_sat, r_ovf;
`endif

    assign w_abort  = bus.i_abort;
    assign w_start  = (r_state == S_IDLE) && bus.i_start && !w_abort;
    assign w_dump   = (r_state == S_DUMP) && !w_abort;
    assign w_run    = !w_abort && (r_state == S_WAIT_SOF || r_state == S_ACCUM || (r_state == S_DUMP && r_cont));
    assign w_clr    = w_abort || (r_state == S_DUMP && !r_cont);
    // in DUMP the base is a fresh frame, seeded with a sof sample held back from a short final frame
    assign w_bpt    = (r_state == S_DUMP) ? CNT_W'(r_carry_v) : r_pt;
    assign w_bcnt   = (r_state == S_DUMP) ? '0 : r_cnt;
    assign w_v      = bus.i_s_valid && w_run;
    assign w_mid    = (w_bpt != '0) && (w_bpt != PT_FULL);
    assign w_short  = w_v && bus.i_sof && w_mid;
    assign w_wr     = w_v && (bus.i_sof || w_mid);
    assign w_long   = w_v && !bus.i_sof && (w_bpt == PT_FULL);
    assign w_idx    = bus.i_sof ? '0 : w_bpt;
    assign w_cmp    = w_wr && (w_idx == PT_LAST);
    assign w_fin_s  = w_short && (w_bcnt == CNT_LAST);
    assign w_fin_c  = w_cmp && !w_short && (w_bcnt == CNT_LAST);
    assign w_fin    = w_fin_s || w_fin_c;
    // a sof that ends a short final frame belongs to the next run, so it is carried past DUMP
    assign w_wr_acc = w_wr && !w_fin_s;
    assign w_pt_nxt = w_fin ? '0 : (w_wr ? w_idx + CNT_W'(1) : w_bpt);
    assign w_cnt_nxt = w_fin ? '0 : w_bcnt + MEAS_W'(w_short) + MEAS_W'(w_cmp);

`ifdef ACCUM_SAT_EN
    assign w_sum_x  = {1'b0, w_sel} + (SUM_W + 1)'(bus.i_s_data);
    assign w_sat    = w_sum_x[SUM_W];
    assign w_sum    = w_sat ? '1 : w_sum_x[SUM_W-1:0];
`else
    assign w_sum    = w_sel + SUM_W'(bus.i_s_data);
`endif

    // Accumulation base per point, addend selection and snapshot read mux
    always_comb begin
        w_sel = '0;
        w_rd  = '0;
        for (int i = 0; i < POINTS; i++) begin
            w_base[i] = (r_state == S_DUMP) ? ((i == 0 && r_carry_v) ? SUM_W'(r_carry_d) : '0) : r_acc[i];
            if (w_idx == CNT_W'(i)) w_sel = w_base[i];
            if (bus.i_rd_addr == PT_W'(i)) w_rd = r_snap[i];
        end
    end

    // Updated sums: the addressed point takes the new sum, the others keep the base
    always_comb begin
        for (int i = 0; i < POINTS; i++)
            w_acc_nxt[i] = (w_wr_acc && w_idx == CNT_W'(i)) ? w_sum : w_base[i];
    end

    // Next state: abort dominates, DUMP returns to IDLE unless the run is continuous
    always_comb begin
        w_state_nxt = r_state;
        w_state_nxt = w_abort ? S_IDLE :
                      (r_state == S_IDLE) ? (bus.i_start ? S_WAIT_SOF : S_IDLE) :
                      (r_state == S_DUMP && !r_cont) ? S_IDLE :
                      w_fin ? S_DUMP :
                      (w_pt_nxt == '0) ? S_WAIT_SOF : S_ACCUM;
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Sums, snapshot, counters, flags and registered readout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < POINTS; i++) begin
                r_acc[i]  <= '0;
                r_snap[i] <= '0;
            end
            r_pt      <= '0;
            r_cnt     <= '0;
            r_cont    <= 1'b0;
            r_short   <= 1'b0;
            r_long    <= 1'b0;
            r_carry_v <= 1'b0;
            r_carry_d <= '0;
            r_rd      <= '0;
`ifdef ACCUM_SAT_EN
            r_ovf     <= 1'b0;
`endif
        end else begin
            r_rd <= w_rd;
            if (w_dump)
                for (int i = 0; i < POINTS; i++) r_snap[i] <= r_acc[i];
            if (w_start) begin
                r_cont  <= bus.i_cont;
                r_short <= 1'b0;
                r_long  <= 1'b0;
`ifdef ACCUM_SAT_EN
                r_ovf   <= 1'b0;
`endif
            end else if (w_run) begin
                r_short <= r_short | w_short;
                r_long  <= r_long | w_long;
`ifdef ACCUM_SAT_EN
                r_ovf   <= r_ovf | (w_sat && w_wr_acc);
`endif
            end
            if (w_clr) begin
                for (int i = 0; i < POINTS; i++) r_acc[i] <= '0;
                r_pt      <= '0;
                r_cnt     <= '0;
                r_carry_v <= 1'b0;
            end else if (w_run) begin
                for (int i = 0; i < POINTS; i++) r_acc[i] <= w_acc_nxt[i];
                r_pt      <= w_pt_nxt;
                r_cnt     <= w_cnt_nxt;
                r_carry_v <= w_fin_s;
                r_carry_d <= bus.i_s_data;
            end
        end
    end

    assign bus.o_rd_data     = r_rd;
    assign bus.o_busy        = (r_state != S_IDLE);
    assign bus.o_done        = w_dump;
    assign bus.o_frame_cnt   = r_cnt;
    assign bus.o_short_frame = r_short;
    assign bus.o_long_frame  = r_long;
`ifdef ACCUM_SAT_EN
    assign bus.o_ovf         = r_ovf;
`endif
endmodule
